// File: rtl/core_l1d_req_queue.sv
// core_l1d_req_queue
//   Request queue between the memory stage and L1D. Load/store requests are
//   buffered in a small FIFO, and one request at a time is kept outstanding to L1D.
//   The outstanding request is the FIFO head. It is presented combinationally and
//   stays stable until l1d_ack. A read completion produces a one-cycle rsp_val
//   pulse that carries the registered l1d_rdata.
//
// Parameters: DEPTH (power of 2, >=2), AW (address width), DW (data width)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_val/in_rdy       push handshake from mem stage (in_rdy = not full)
//   in_addr/cop/wdata/size  request fields
//   l1d_req_*           head request to L1D, l1d_ack completes it
//   l1d_rdata           load data, valid with l1d_ack on reads
//   rsp_val/rsp_rdata   load response pulse to writeback
//   occupancy           entries held, including the outstanding one
//   misalign_err        misaligned-request pulse
//
// Build option: CORE_L1D_MISALIGN_CHK_EN. When it is defined, misaligned
//   half/word requests are dropped at the handshake and flagged on misalign_err.
//   When it is undefined, every request is queued and misalign_err is tied 0.
module core_l1d_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [AW-1:0]            in_addr,
  input  logic [2:0]               in_cop,
  input  logic [DW-1:0]            in_wdata,
  input  logic [2:0]               in_size,
  output logic                     l1d_req_val,
  output logic [AW-1:0]            l1d_req_addr,
  output logic [2:0]               l1d_req_cop,
  output logic [DW-1:0]            l1d_req_wdata,
  output logic [2:0]               l1d_req_size,
  input  logic                     l1d_ack,
  input  logic [DW-1:0]            l1d_rdata,
  output logic                     rsp_val,
  output logic [DW-1:0]            rsp_rdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          r_state, w_state_nxt;

  logic [AW-1:0]   r_addr  [DEPTH];
  logic [2:0]      r_cop   [DEPTH];
  logic [DW-1:0]   r_wdata [DEPTH];
  logic [2:0]      r_size  [DEPTH];

  logic [PW-1:0]   r_wptr, r_rptr;
  logic [OW-1:0]   r_occ, w_occ_nxt;
  logic            r_rsp_val;
  logic [DW-1:0]   r_rsp_rdata;

  logic            w_in_rdy, w_accept, w_push, w_pop;

  assign w_in_rdy = (r_occ != OW'(DEPTH));
  assign w_accept = in_val & w_in_rdy;

`ifdef CORE_L1D_MISALIGN_CHK_EN
  logic w_misalign;
  logic r_misalign;
  assign w_misalign = ((in_size == 3'b001) && in_addr[0]) ||
                      ((in_size == 3'b010) && (in_addr[1:0] != 2'b00));
  assign w_push     = w_accept & ~w_misalign;

  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_accept & w_misalign;
  end
  assign misalign_err = r_misalign;
`else
  assign w_push       = w_accept;
  assign misalign_err = 1'b0;
`endif

  // A pop is possible only while a request is presented, so an ack in IDLE is ignored.
  assign w_pop = (r_state == S_REQ) & l1d_ack;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + OW'(1);
      2'b01:   w_occ_nxt = r_occ - OW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // The next-cycle occupancy drives the FSM. A push into an empty queue is then
  // presented the next cycle, and an ack is followed back-to-back by the next head.
  always_comb begin
    w_state_nxt = r_state;
    l1d_req_val = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_occ_nxt != '0) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        l1d_req_val = 1'b1;
        if (l1d_ack && (w_occ_nxt == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_occ <= w_occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr]  <= in_addr;
      r_cop[r_wptr]   <= in_cop;
      r_wdata[r_wptr] <= in_wdata;
      r_size[r_wptr]  <= in_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_val   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_val <= w_pop & ~r_cop[r_rptr][0];
      if (w_pop & ~r_cop[r_rptr][0]) r_rsp_rdata <= l1d_rdata;
    end
  end

  assign in_rdy        = w_in_rdy;
  assign l1d_req_addr  = r_addr[r_rptr];
  assign l1d_req_cop   = r_cop[r_rptr];
  assign l1d_req_wdata = r_wdata[r_rptr];
  assign l1d_req_size  = r_size[r_rptr];
  assign rsp_val       = r_rsp_val;
  assign rsp_rdata     = r_rsp_rdata;
  assign occupancy     = r_occ;

endmodule

// File: tb/tb_core_l1d_req_queue.sv
module tb_core_l1d_req_queue;

  logic        clk;
  logic        rst;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_addr;
  logic [2:0]  in_cop;
  logic [31:0] in_wdata;
  logic [2:0]  in_size;
  logic        l1d_req_val;
  logic [31:0] l1d_req_addr;
  logic [2:0]  l1d_req_cop;
  logic [31:0] l1d_req_wdata;
  logic [2:0]  l1d_req_size;
  logic        l1d_ack;
  logic [31:0] l1d_rdata;
  logic        rsp_val;
  logic [31:0] rsp_rdata;
  logic [2:0]  occupancy;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  core_l1d_req_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_addr(in_addr), .in_cop(in_cop),
    .in_wdata(in_wdata), .in_size(in_size),
    .l1d_req_val(l1d_req_val), .l1d_req_addr(l1d_req_addr), .l1d_req_cop(l1d_req_cop),
    .l1d_req_wdata(l1d_req_wdata), .l1d_req_size(l1d_req_size),
    .l1d_ack(l1d_ack), .l1d_rdata(l1d_rdata),
    .rsp_val(rsp_val), .rsp_rdata(rsp_rdata),
    .occupancy(occupancy), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        val;
    logic [31:0] addr;
    logic [2:0]  cop;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [2:0]  e_cop;
    logic [31:0] e_wdata;
    logic [2:0]  e_occ;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic v, logic [31:0] a, logic [2:0] c, logic [31:0] wd,
                              logic ak, logic [31:0] rd, logic er, logic [31:0] ea,
                              logic [2:0] ec, logic [31:0] ew, logic [2:0] eo,
                              logic ey, logic es, logic [31:0] erd);
    vec_t t;
    t.val = v; t.addr = a; t.cop = c; t.wdata = wd; t.ack = ak; t.rdata = rd;
    t.e_req = er; t.e_addr = ea; t.e_cop = ec; t.e_wdata = ew; t.e_occ = eo;
    t.e_rdy = ey; t.e_rsp = es; t.e_rdata = erd;
    return t;
  endfunction

  function automatic logic [31:0] wd_of(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_val = 1'b0; in_addr = '0; in_cop = '0; in_wdata = '0; in_size = 3'b010;
    l1d_ack = 1'b0; l1d_rdata = '0;
  endtask

  logic [31:0] exp_q[$];
  int sent, recv;

  initial begin
    // Test 1: single read. Test 2: fill to full, rejected push, drain back-to-back.
    vecs[0]  = mk(1, 32'h100, 3'd0, 32'h0, 0, 32'h0,        1, 32'h100, 3'd0, 32'h0, 3'd1, 1, 0, 32'h0);
    vecs[1]  = mk(0, 32'h0,   3'd0, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0,   3'd0, 32'h0, 3'd0, 1, 1, 32'hDEADBEEF);
    vecs[2]  = mk(0, 32'h0,   3'd0, 32'h0, 0, 32'h0,        0, 32'h0,   3'd0, 32'h0, 3'd0, 1, 0, 32'h0);
    vecs[3]  = mk(1, 32'h200, 3'd1, wd_of(32'h200), 0, 0,   1, 32'h200, 3'd1, wd_of(32'h200), 3'd1, 1, 0, 0);
    vecs[4]  = mk(1, 32'h204, 3'd1, wd_of(32'h204), 0, 0,   1, 32'h200, 3'd1, wd_of(32'h200), 3'd2, 1, 0, 0);
    vecs[5]  = mk(1, 32'h208, 3'd1, wd_of(32'h208), 0, 0,   1, 32'h200, 3'd1, wd_of(32'h200), 3'd3, 1, 0, 0);
    vecs[6]  = mk(1, 32'h20C, 3'd1, wd_of(32'h20C), 0, 0,   1, 32'h200, 3'd1, wd_of(32'h200), 3'd4, 0, 0, 0);
    vecs[7]  = mk(1, 32'h210, 3'd1, wd_of(32'h210), 0, 0,   1, 32'h200, 3'd1, wd_of(32'h200), 3'd4, 0, 0, 0);
    // Full with a pop in the same cycle: the push is still refused.
    vecs[8]  = mk(1, 32'h210, 3'd1, wd_of(32'h210), 1, 0,   1, 32'h204, 3'd1, wd_of(32'h204), 3'd3, 1, 0, 0);
    vecs[9]  = mk(0, 32'h0,   3'd0, 32'h0, 1, 0,            1, 32'h208, 3'd1, wd_of(32'h208), 3'd2, 1, 0, 0);
    vecs[10] = mk(0, 32'h0,   3'd0, 32'h0, 1, 0,            1, 32'h20C, 3'd1, wd_of(32'h20C), 3'd1, 1, 0, 0);
    vecs[11] = mk(0, 32'h0,   3'd0, 32'h0, 1, 0,            0, 32'h0,   3'd0, 32'h0, 3'd0, 1, 0, 0);

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_req_val", 32'(l1d_req_val), 32'd0);
    chk("rst_rsp_val", 32'(rsp_val), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      in_val = vecs[i].val; in_addr = vecs[i].addr; in_cop = vecs[i].cop;
      in_wdata = vecs[i].wdata; in_size = 3'b010;
      l1d_ack = vecs[i].ack; l1d_rdata = vecs[i].rdata;
      step();
      chk($sformatf("v%0d_req_val", i), 32'(l1d_req_val), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_rsp_val", i), 32'(rsp_val), 32'(vecs[i].e_rsp));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), l1d_req_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_cop", i), 32'(l1d_req_cop), 32'(vecs[i].e_cop));
        chk($sformatf("v%0d_wdata", i), l1d_req_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_size", i), 32'(l1d_req_size), 32'd2);
      end
      if (vecs[i].e_rsp) chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
    end
    idle_inputs();

    // Test 3: stall hold, then push and pop together.
    in_val = 1; in_addr = 32'h300; in_cop = 3'd0; in_size = 3'b010;
    step();
    in_addr = 32'h304; in_cop = 3'd1; in_wdata = 32'h55;
    step();
    in_val = 0;
    chk("stall_occ0", 32'(occupancy), 32'd2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_req_val", 32'(l1d_req_val), 32'd1);
      chk("stall_addr", l1d_req_addr, 32'h300);
      chk("stall_cop", 32'(l1d_req_cop), 32'd0);
      chk("stall_occ", 32'(occupancy), 32'd2);
    end
    in_val = 1; in_addr = 32'h308; in_cop = 3'd0; in_wdata = 32'h0;
    l1d_ack = 1; l1d_rdata = 32'h1111_2222;
    step();
    in_val = 0; l1d_ack = 0;
    chk("pp_occ", 32'(occupancy), 32'd2);
    chk("pp_addr", l1d_req_addr, 32'h304);
    chk("pp_wdata", l1d_req_wdata, 32'h55);
    chk("pp_rsp_val", 32'(rsp_val), 32'd1);
    chk("pp_rsp_rdata", rsp_rdata, 32'h1111_2222);
    l1d_ack = 1;
    step();
    chk("wr_no_rsp", 32'(rsp_val), 32'd0);
    chk("drain_addr", l1d_req_addr, 32'h308);
    chk("drain_occ", 32'(occupancy), 32'd1);
    l1d_rdata = 32'h3333_4444;
    step();
    l1d_ack = 0;
    chk("drain_empty", 32'(l1d_req_val), 32'd0);
    chk("drain_rsp_val", 32'(rsp_val), 32'd1);
    chk("drain_rsp_rdata", rsp_rdata, 32'h3333_4444);
    step();
    chk("rsp_one_cycle", 32'(rsp_val), 32'd0);

    // Test 4: wrap, 10 requests through a 4-entry queue with irregular acks.
    sent = 0; recv = 0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      in_val = (sent < 10) && in_rdy;
      in_addr = 32'h500 + 32'(sent) * 4;
      in_cop = 3'(sent & 1);
      in_wdata = 32'(sent);
      in_size = 3'b010;
      l1d_ack = l1d_req_val && (c % 3 != 1);
      if (l1d_ack) begin
        chk("wrap_addr", l1d_req_addr, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
        recv++;
      end
      if (in_val) begin
        exp_q.push_back(in_addr);
        sent++;
      end
      step();
    end
    idle_inputs();
    chk("wrap_count", 32'(recv), 32'd10);
    chk("wrap_occ", 32'(occupancy), 32'd0);

    // Test 5: reset with 3 entries and an outstanding read.
    in_val = 1; in_cop = 3'd0;
    for (int k = 0; k < 3; k++) begin
      in_addr = 32'h400 + 32'(k) * 4;
      step();
    end
    in_val = 0;
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    chk("pre_rst_addr", l1d_req_addr, 32'h400);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_req_val", 32'(l1d_req_val), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
    l1d_ack = 1; l1d_rdata = 32'h9;
    step();
    l1d_ack = 0;
    chk("late_ack_rsp", 32'(rsp_val), 32'd0);
    chk("late_ack_occ", 32'(occupancy), 32'd0);

    // Test 6: word at 0x102.
    in_val = 1; in_addr = 32'h102; in_cop = 3'd0; in_size = 3'b010;
    step();
    in_val = 0;
`ifdef CORE_L1D_MISALIGN_CHK_EN
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_occ", 32'(occupancy), 32'd0);
    chk("mis_req_val", 32'(l1d_req_val), 32'd0);
    step();
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);
    chk("mis_req_val2", 32'(l1d_req_val), 32'd0);
`else
    chk("mis_err_tied", 32'(misalign_err), 32'd0);
    chk("mis_req_val", 32'(l1d_req_val), 32'd1);
    chk("mis_addr", l1d_req_addr, 32'h102);
    chk("mis_occ", 32'(occupancy), 32'd1);
    l1d_ack = 1;
    step();
    l1d_ack = 0;
    chk("mis_drain_occ", 32'(occupancy), 32'd0);
`endif
    // An aligned half at 0x102 is queued in both builds.
    in_val = 1; in_addr = 32'h102; in_size = 3'b001;
    step();
    in_val = 0;
    chk("half_err", 32'(misalign_err), 32'd0);
    chk("half_req_val", 32'(l1d_req_val), 32'd1);
    chk("half_addr", l1d_req_addr, 32'h102);
    chk("half_size", 32'(l1d_req_size), 32'd1);
    l1d_ack = 1;
    step();
    l1d_ack = 0;
    chk("half_drain_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
